// File: rtl/fpa_pkg.sv
// Shared types and constants for the FP array accumulator feeder.
package fpa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    CLR,
    RUN,
    HOLD
  } loader_state_t;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  localparam logic [1:0] FPA_OP_ADD = 2'b00;
  localparam logic [1:0] FPA_OP_SUB = 2'b01;
  localparam logic [1:0] FPA_OP_MUL = 2'b10;
  localparam logic [1:0] FPA_OP_DIV = 2'b11;

  // Bit positions inside oFLAGS.
  localparam int unsigned FLAG_OVF   = 0;
  localparam int unsigned FLAG_UNF   = 1;
  localparam int unsigned FLAG_EXC   = 2;
  localparam int unsigned FLAG_NAN   = 3;
  localparam int unsigned FLAG_TMO   = 4;
  localparam int unsigned FLAG_WIDTH = 5;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier.
module fp_classify (
  input  logic [31:0] fp_i,
  output logic        is_nan_o,
  output logic        is_inf_o,
  output logic        is_zero_o
);

  logic [7:0]  exp_w;
  logic [22:0] mant_w;

  assign exp_w  = fp_i[30:23];
  assign mant_w = fp_i[22:0];

  // Sign is irrelevant to all three classes.
  assign is_nan_o  = (exp_w == 8'hFF) && (mant_w != 23'd0);
  assign is_inf_o  = (exp_w == 8'hFF) && (mant_w == 23'd0);
  assign is_zero_o = (exp_w == 8'h00) && (mant_w == 23'd0) && (fp_i[31] | ~fp_i[31]);

endmodule

// File: rtl/fpa_array_loader.sv
// Collects an FP32 frame into an N+1 operand buffer, pads with +0.0, runs the accumulator
// and hands back its result and flags on a valid/ready result port.
module fpa_array_loader
  import fpa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned N           = 16,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                       iCLK,
  input  logic                       iNRESET,
  input  logic                       iS_VALID,
  input  logic [DATA_WIDTH-1:0]      iS_DATA,
  input  logic                       iS_LAST,
  output logic                       oS_READY,
  input  logic [1:0]                 iOPERATION,
  output logic [N:0][DATA_WIDTH-1:0] oFPA_NUMBERS,
  output logic [1:0]                 oFPA_OPERATION,
  output logic                       oFPA_CLR,
  output logic                       oFPA_EN,
  input  logic                       iFPA_DATA_VALID,
  input  logic [DATA_WIDTH-1:0]      iFPA_RESULT,
  input  logic                       iFPA_OVERFLOW,
  input  logic                       iFPA_UNDERFLOW,
  input  logic                       iFPA_EXCEPTION,
  output logic [DATA_WIDTH-1:0]      oRESULT,
  output logic [FLAG_WIDTH-1:0]      oFLAGS,
  output logic                       oRESULT_VALID,
  input  logic                       iRESULT_READY,
  output logic                       oBUSY
);

  localparam int unsigned CW = $clog2(N + 2);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LastSlot = CW'(N);
  localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT_CYC - 1);

  loader_state_t               state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [N:0][DATA_WIDTH-1:0]  buf_q, buf_d;
  logic [1:0]                  op_q, op_d;
  logic                        nan_q, nan_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]       res_q, res_d;
  logic [FLAG_WIDTH-1:0]       flags_q, flags_d;
  logic                        live_q;

  logic                        s_ready;
  logic                        accept;
  logic                        wr_en;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic                        word_nan;
  logic                        word_inf;
  logic                        word_zero;

  fp_classify u_classify (
    .fp_i      (iS_DATA[31:0]),
    .is_nan_o  (word_nan),
    .is_inf_o  (word_inf),
    .is_zero_o (word_zero)
  );

  // live_q keeps the input port closed until the first clock after reset release.
  assign s_ready = live_q && ((state_q == IDLE) || (state_q == FILL));
  assign accept  = iS_VALID && s_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    nan_d   = nan_q;
    tmo_d   = tmo_q;
    res_d   = res_q;
    flags_d = flags_q;
    wr_en   = 1'b0;
    wr_data = iS_DATA;

    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_en = 1'b1;
          op_d  = iOPERATION;
          nan_d = word_nan;
          cnt_d = CW'(1);
          if (N == 0) begin
            state_d = CLR;
          end else if (iS_LAST) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          nan_d = nan_q | word_nan;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LastSlot) begin
            state_d = CLR;
          end else if (iS_LAST) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        wr_en   = 1'b1;
        wr_data = DATA_WIDTH'(FP_POS_ZERO);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LastSlot) begin
          state_d = CLR;
        end
      end
      CLR: begin
        tmo_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        tmo_d = tmo_q + TW'(1);
        // A result arriving on the timeout cycle takes priority.
        if (iFPA_DATA_VALID) begin
          res_d             = iFPA_RESULT;
          flags_d           = '0;
          flags_d[FLAG_OVF] = iFPA_OVERFLOW;
          flags_d[FLAG_UNF] = iFPA_UNDERFLOW;
          flags_d[FLAG_EXC] = iFPA_EXCEPTION;
          flags_d[FLAG_NAN] = nan_q;
          state_d           = HOLD;
        end else if (tmo_q == TmoLast) begin
          res_d             = DATA_WIDTH'(FP_QNAN);
          flags_d           = '0;
          flags_d[FLAG_NAN] = nan_q;
          flags_d[FLAG_TMO] = 1'b1;
          state_d           = HOLD;
        end
      end
      HOLD: begin
        if (iRESULT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d = buf_q;
    for (int unsigned i = 0; i <= N; i++) begin
      if (wr_en && (cnt_q == CW'(i))) begin
        buf_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iNRESET) begin
    if (!iNRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      op_q    <= '0;
      nan_q   <= 1'b0;
      tmo_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      op_q    <= op_d;
      nan_q   <= nan_d;
      tmo_q   <= tmo_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      live_q  <= 1'b1;
    end
  end

  assign oS_READY       = s_ready;
  assign oFPA_NUMBERS   = buf_q;
  assign oFPA_OPERATION = op_q;
  assign oFPA_CLR       = (state_q == CLR);
  assign oFPA_EN        = (state_q == RUN);
  assign oRESULT        = res_q;
  assign oFLAGS         = flags_q;
  assign oRESULT_VALID  = (state_q == HOLD);
  assign oBUSY          = (state_q != IDLE);

  logic unused_class;
  assign unused_class = word_inf ^ word_zero;

endmodule

// File: tb/tb_fpa_array_loader.sv
// Directed self-checking bench for fpa_array_loader (N=16, TIMEOUT_CYC=64).
module tb_fpa_array_loader;
  import fpa_pkg::*;

  localparam int unsigned N = 16;

  logic              iCLK = 1'b0;
  logic              iNRESET;
  logic              iS_VALID;
  logic [31:0]       iS_DATA;
  logic              iS_LAST;
  logic              oS_READY;
  logic [1:0]        iOPERATION;
  logic [N:0][31:0]  oFPA_NUMBERS;
  logic [1:0]        oFPA_OPERATION;
  logic              oFPA_CLR;
  logic              oFPA_EN;
  logic              iFPA_DATA_VALID;
  logic [31:0]       iFPA_RESULT;
  logic              iFPA_OVERFLOW;
  logic              iFPA_UNDERFLOW;
  logic              iFPA_EXCEPTION;
  logic [31:0]       oRESULT;
  logic [4:0]        oFLAGS;
  logic              oRESULT_VALID;
  logic              iRESULT_READY;
  logic              oBUSY;

  int n_chk = 0;
  int n_err = 0;

  fpa_array_loader #(
    .DATA_WIDTH  (32),
    .N           (N),
    .TIMEOUT_CYC (64)
  ) dut (
    .iCLK            (iCLK),
    .iNRESET         (iNRESET),
    .iS_VALID        (iS_VALID),
    .iS_DATA         (iS_DATA),
    .iS_LAST         (iS_LAST),
    .oS_READY        (oS_READY),
    .iOPERATION      (iOPERATION),
    .oFPA_NUMBERS    (oFPA_NUMBERS),
    .oFPA_OPERATION  (oFPA_OPERATION),
    .oFPA_CLR        (oFPA_CLR),
    .oFPA_EN         (oFPA_EN),
    .iFPA_DATA_VALID (iFPA_DATA_VALID),
    .iFPA_RESULT     (iFPA_RESULT),
    .iFPA_OVERFLOW   (iFPA_OVERFLOW),
    .iFPA_UNDERFLOW  (iFPA_UNDERFLOW),
    .iFPA_EXCEPTION  (iFPA_EXCEPTION),
    .oRESULT         (oRESULT),
    .oFLAGS          (oFLAGS),
    .oRESULT_VALID   (oRESULT_VALID),
    .iRESULT_READY   (iRESULT_READY),
    .oBUSY           (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    chk("beat_ready", {31'd0, oS_READY}, 32'd1);
    iS_VALID = 1'b1;
    iS_DATA  = d;
    iS_LAST  = last;
    tick();
    iS_VALID = 1'b0;
    iS_LAST  = 1'b0;
  endtask

  task automatic wait_clr(input string tag);
    int n = 0;
    while (!oFPA_CLR && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, oFPA_CLR}, 32'd1);
  endtask

  // Slots below nfull hold 1.0, the rest must be +0.0.
  task automatic chk_buf(input string tag, input int unsigned nfull);
    for (int unsigned i = 0; i <= N; i++) begin
      chk($sformatf("%s[%0d]", tag, i), oFPA_NUMBERS[i],
          (i < nfull) ? 32'h3F80_0000 : 32'h0000_0000);
    end
  endtask

  // From CLR: one RUN cycle, then the model returns a result.
  task automatic finish_frame(input logic [31:0] r, input logic ovf, input logic unf,
                              input logic exc);
    tick();
    chk("run_en", {31'd0, oFPA_EN}, 32'd1);
    iFPA_DATA_VALID = 1'b1;
    iFPA_RESULT     = r;
    iFPA_OVERFLOW   = ovf;
    iFPA_UNDERFLOW  = unf;
    iFPA_EXCEPTION  = exc;
    tick();
    iFPA_DATA_VALID = 1'b0;
    iFPA_RESULT     = 32'h0;
    iFPA_OVERFLOW   = 1'b0;
    iFPA_UNDERFLOW  = 1'b0;
    iFPA_EXCEPTION  = 1'b0;
    chk("hold_valid", {31'd0, oRESULT_VALID}, 32'd1);
    chk("hold_en_off", {31'd0, oFPA_EN}, 32'd0);
  endtask

  task automatic release_result();
    iRESULT_READY = 1'b1;
    tick();
    iRESULT_READY = 1'b0;
    chk("rel_rvalid", {31'd0, oRESULT_VALID}, 32'd0);
    chk("rel_ready", {31'd0, oS_READY}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iNRESET = 1'b0;
    iS_VALID = 1'b0;
    iS_DATA = 32'h0;
    iS_LAST = 1'b0;
    iOPERATION = 2'b00;
    iFPA_DATA_VALID = 1'b0;
    iFPA_RESULT = 32'h0;
    iFPA_OVERFLOW = 1'b0;
    iFPA_UNDERFLOW = 1'b0;
    iFPA_EXCEPTION = 1'b0;
    iRESULT_READY = 1'b0;

    // Reset state
    #12;
    chk("rst_ready", {31'd0, oS_READY}, 32'd0);
    chk("rst_busy", {31'd0, oBUSY}, 32'd0);
    chk("rst_en", {31'd0, oFPA_EN}, 32'd0);
    chk("rst_clr", {31'd0, oFPA_CLR}, 32'd0);
    chk("rst_rvalid", {31'd0, oRESULT_VALID}, 32'd0);
    chk("rst_result", oRESULT, 32'h0);
    chk("rst_flags", {27'd0, oFLAGS}, 32'h0);
    chk("rst_op", {30'd0, oFPA_OPERATION}, 32'h0);
    chk_buf("rst_buf", 0);
    tick();
    iNRESET = 1'b1;
    chk("rel_ready0", {31'd0, oS_READY}, 32'd0);
    tick();
    chk("rel_ready1", {31'd0, oS_READY}, 32'd1);

    // 1: full frame of 17 x 1.0
    iOPERATION = FPA_OP_SUB;
    for (int i = 0; i < 17; i++) begin
      beat(32'h3F80_0000, (i == 16));
      iOPERATION = FPA_OP_MUL;
    end
    chk("t1_clr", {31'd0, oFPA_CLR}, 32'd1);
    chk("t1_ready", {31'd0, oS_READY}, 32'd0);
    chk("t1_op", {30'd0, oFPA_OPERATION}, {30'd0, FPA_OP_SUB});
    chk_buf("t1_buf", 17);
    tick();
    chk("t1_clr_once", {31'd0, oFPA_CLR}, 32'd0);
    chk("t1_en", {31'd0, oFPA_EN}, 32'd1);
    tick();
    iFPA_DATA_VALID = 1'b1;
    iFPA_RESULT = 32'h4188_0000;
    tick();
    iFPA_DATA_VALID = 1'b0;
    iFPA_RESULT = 32'h0;
    chk("t1_rvalid", {31'd0, oRESULT_VALID}, 32'd1);
    chk("t1_result", oRESULT, 32'h4188_0000);
    chk("t1_flags", {27'd0, oFLAGS}, 32'h0);
    chk("t1_en_off", {31'd0, oFPA_EN}, 32'd0);
    tick();
    chk("t1_result_held", oRESULT, 32'h4188_0000);
    release_result();
    chk("t1_idle", {31'd0, oBUSY}, 32'd0);

    // 2: short frame, 14 pad slots
    beat(32'h3F80_0000, 1'b0);
    beat(32'h3F80_0000, 1'b0);
    beat(32'h3F80_0000, 1'b1);
    chk("t2_pad_ready", {31'd0, oS_READY}, 32'd0);
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("t2_pad_ready_%0d", k), {31'd0, oS_READY}, 32'd0);
    end
    chk("t2_no_clr_yet", {31'd0, oFPA_CLR}, 32'd0);
    tick();
    chk("t2_clr", {31'd0, oFPA_CLR}, 32'd1);
    chk_buf("t2_buf", 3);
    finish_frame(32'h4040_0000, 1'b1, 1'b0, 1'b0);
    chk("t2_result", oRESULT, 32'h4040_0000);
    chk("t2_flags", {27'd0, oFLAGS}, 32'h01);
    release_result();

    // 3: full frame with no last, then timeout
    for (int i = 0; i < 17; i++) begin
      beat(32'h4000_0000, 1'b0);
    end
    chk("t3_full_clr", {31'd0, oFPA_CLR}, 32'd1);
    tick();
    for (int k = 1; k <= 63; k++) begin
      tick();
    end
    chk("t3_en_63", {31'd0, oFPA_EN}, 32'd1);
    chk("t3_rvalid_63", {31'd0, oRESULT_VALID}, 32'd0);
    tick();
    chk("t3_rvalid_64", {31'd0, oRESULT_VALID}, 32'd1);
    chk("t3_result", oRESULT, 32'h7FC0_0000);
    chk("t3_flags", {27'd0, oFLAGS}, 32'h10);
    release_result();

    // 4: NaN on beat 2, then clean frame
    iOPERATION = FPA_OP_ADD;
    beat(32'h3F80_0000, 1'b0);
    beat(32'h7FC0_0001, 1'b0);
    beat(32'h3F80_0000, 1'b1);
    wait_clr("t4_clr");
    chk("t4_slot1", oFPA_NUMBERS[1], 32'h7FC0_0001);
    chk("t4_slot3", oFPA_NUMBERS[3], 32'h0);
    finish_frame(32'h7FC0_0000, 1'b0, 1'b0, 1'b1);
    chk("t4_flags_nan", {27'd0, oFLAGS}, 32'h0C);
    release_result();
    beat(32'h3F80_0000, 1'b0);
    beat(32'h4000_0000, 1'b1);
    wait_clr("t4b_clr");
    finish_frame(32'h4040_0000, 1'b0, 1'b0, 1'b0);
    chk("t4b_flags", {27'd0, oFLAGS}, 32'h0);
    chk("t4b_result", oRESULT, 32'h4040_0000);
    release_result();

    // 5: reset during RUN
    beat(32'h3F80_0000, 1'b1);
    wait_clr("t5_clr");
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    chk("t5_en_run", {31'd0, oFPA_EN}, 32'd1);
    iNRESET = 1'b0;
    #1;
    chk("t5_en", {31'd0, oFPA_EN}, 32'd0);
    chk("t5_busy", {31'd0, oBUSY}, 32'd0);
    chk("t5_rvalid", {31'd0, oRESULT_VALID}, 32'd0);
    chk("t5_result", oRESULT, 32'h0);
    chk("t5_ready", {31'd0, oS_READY}, 32'd0);
    chk_buf("t5_buf", 0);
    tick();
    iNRESET = 1'b1;
    chk("t5_ready_rel0", {31'd0, oS_READY}, 32'd0);
    tick();
    chk("t5_ready_rel1", {31'd0, oS_READY}, 32'd1);
    chk("t5_no_rvalid", {31'd0, oRESULT_VALID}, 32'd0);

    // 6: long HOLD with traffic on the input port
    beat(32'h3F80_0000, 1'b1);
    wait_clr("t6_clr");
    finish_frame(32'h3F80_0000, 1'b0, 1'b1, 1'b0);
    chk("t6_flags", {27'd0, oFLAGS}, 32'h02);
    iS_VALID = 1'b1;
    iS_DATA  = 32'h4000_0000;
    iS_LAST  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("t6_result_%0d", k), oRESULT, 32'h3F80_0000);
      chk($sformatf("t6_ready_%0d", k), {31'd0, oS_READY}, 32'd0);
    end
    chk("t6_rvalid", {31'd0, oRESULT_VALID}, 32'd1);
    chk("t6_slot0", oFPA_NUMBERS[0], 32'h3F80_0000);
    iS_VALID = 1'b0;
    iS_LAST  = 1'b0;
    release_result();
    chk("t6_idle", {31'd0, oBUSY}, 32'd0);
    chk("t6_slot0_after", oFPA_NUMBERS[0], 32'h3F80_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
